// File: rtl/fpu_resp_buffer_if.sv
// fpu_resp_buffer_if: handshake bundle for the FPU response buffer.
// Carries issue credit, the unstallable FPU response (enq_*), branch updates,
// flush, the writeback dequeue port (deq_*), the fflags report and the overflow flag.
// master = environment side (FPU unit, branch unit, writeback), slave = buffer.
interface fpu_resp_buffer_if #(
  parameter int BR_W   = 20,
  parameter int DATA_W = 65
);
  logic              issue_fire;
  logic              issue_ready;
  logic              enq_valid;
  logic [6:0]        enq_rob_idx;
  logic [6:0]        enq_pdst;
  logic [1:0]        enq_dst_rtype;
  logic [BR_W-1:0]   enq_br_mask;
  logic [DATA_W-1:0] enq_data;
  logic              enq_fflags_valid;
  logic [4:0]        enq_fflags;
  logic [BR_W-1:0]   brupdate_b1_resolve_mask;
  logic [BR_W-1:0]   brupdate_b1_mispredict_mask;
  logic              flush;
  logic              deq_valid;
  logic              deq_ready;
  logic [6:0]        deq_rob_idx;
  logic [6:0]        deq_pdst;
  logic [1:0]        deq_dst_rtype;
  logic [BR_W-1:0]   deq_br_mask;
  logic [DATA_W-1:0] deq_data;
  logic              fflags_valid;
  logic [6:0]        fflags_rob_idx;
  logic [4:0]        fflags_bits;
  logic              overflow;
  modport master (
    output issue_fire, enq_valid, enq_rob_idx, enq_pdst, enq_dst_rtype, enq_br_mask,
           enq_data, enq_fflags_valid, enq_fflags, brupdate_b1_resolve_mask,
           brupdate_b1_mispredict_mask, flush, deq_ready,
    input  issue_ready, deq_valid, deq_rob_idx, deq_pdst, deq_dst_rtype, deq_br_mask,
           deq_data, fflags_valid, fflags_rob_idx, fflags_bits, overflow
  );
  modport slave (
    input  issue_fire, enq_valid, enq_rob_idx, enq_pdst, enq_dst_rtype, enq_br_mask,
           enq_data, enq_fflags_valid, enq_fflags, brupdate_b1_resolve_mask,
           brupdate_b1_mispredict_mask, flush, deq_ready,
    output issue_ready, deq_valid, deq_rob_idx, deq_pdst, deq_dst_rtype, deq_br_mask,
           deq_data, fflags_valid, fflags_rob_idx, fflags_bits, overflow
  );
endinterface

// File: rtl/fpu_resp_buffer.sv
// fpu_resp_buffer: response FIFO for the fixed-latency FPU unit with branch kill and issue credit.
// Ports: clock (rising edge), reset (async, active-low), io (fpu_resp_buffer_if.slave):
//   issue_fire/issue_ready credit, enq_* response in, brupdate masks, flush,
//   deq_* writeback out, fflags_* report, sticky overflow.
// Optional: define FPU_RESP_BUF_BYPASS_EN for a 0-cycle path when the FIFO is empty.
module fpu_resp_buffer #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 4,
  parameter int BR_W    = 20,
  parameter int DATA_W  = 65
) (
  input logic              clock,
  input logic              reset,
  fpu_resp_buffer_if.slave io
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0]     head, tail;
  logic [PW:0]       count;
  logic [LATENCY-1:0] fire_sr;
  logic [DEPTH-1:0]  live;
  logic [DEPTH-1:0]  ffv_q;
  logic [6:0]        rob_q   [DEPTH];
  logic [6:0]        pdst_q  [DEPTH];
  logic [1:0]        rtype_q [DEPTH];
  logic [BR_W-1:0]   br_q    [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [4:0]        ff_q    [DEPTH];
  logic              overflow_q;
  logic [BR_W-1:0]   res, mis;
  logic              empty, full, enq_ok, head_ok, byp, deq_fire, push, pop;
  assign res      = io.brupdate_b1_resolve_mask;
  assign mis      = io.brupdate_b1_mispredict_mask;
  assign empty    = count == '0;
  assign full     = count == (PW+1)'(DEPTH);
  assign enq_ok   = io.enq_valid & ~|(io.enq_br_mask & mis) & ~io.flush;
  assign head_ok  = ~empty & live[head] & ~|(br_q[head] & mis) & ~io.flush;
`ifdef FPU_RESP_BUF_BYPASS_EN
  assign byp      = empty & enq_ok & io.deq_ready;
`else
  assign byp      = 1'b0;
`endif
  assign deq_fire = (head_ok | byp) & io.deq_ready;
  // A bypassed response is consumed directly and never occupies a slot.
  assign push     = enq_ok & ~full & ~byp;
  // Killed heads (holes) retire silently, one per cycle.
  assign pop      = ~empty & ((head_ok & io.deq_ready) | ~live[head]);
  always_comb begin
    io.deq_valid      = head_ok | byp;
    io.deq_rob_idx    = byp ? io.enq_rob_idx : rob_q[head];
    io.deq_pdst       = byp ? io.enq_pdst : pdst_q[head];
    io.deq_dst_rtype  = byp ? io.enq_dst_rtype : rtype_q[head];
    io.deq_br_mask    = (byp ? io.enq_br_mask : br_q[head]) & ~res;
    io.deq_data       = byp ? io.enq_data : data_q[head];
    io.fflags_valid   = deq_fire & (byp ? io.enq_fflags_valid : ffv_q[head]);
    io.fflags_rob_idx = byp ? io.enq_rob_idx : rob_q[head];
    io.fflags_bits    = byp ? io.enq_fflags : ff_q[head];
    // Conservative credit: in-flight ops keep their slot until they leave the shift register.
    io.issue_ready    = int'(count) + $countones(fire_sr) < DEPTH;
    io.overflow       = overflow_q;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      fire_sr    <= '0;
      live       <= '0;
      overflow_q <= 1'b0;
    end else begin
      head       <= head + PW'(pop);
      tail       <= tail + PW'(push);
      count      <= count + (PW+1)'(push) - (PW+1)'(pop);
      fire_sr    <= {fire_sr[LATENCY-2:0], io.issue_fire};
      overflow_q <= overflow_q | (enq_ok & full);
      for (int i = 0; i < DEPTH; i++)
        live[i] <= (live[i] & ~|(br_q[i] & ~res & mis) & ~io.flush & ~(pop && PW'(i) == head))
                   | (push && PW'(i) == tail);
    end
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++)
      br_q[i] <= ((push && PW'(i) == tail) ? io.enq_br_mask : br_q[i]) & ~res;
    if (push) begin
      rob_q[tail]   <= io.enq_rob_idx;
      pdst_q[tail]  <= io.enq_pdst;
      rtype_q[tail] <= io.enq_dst_rtype;
      data_q[tail]  <= io.enq_data;
      ffv_q[tail]   <= io.enq_fflags_valid;
      ff_q[tail]    <= io.enq_fflags;
    end
  end
endmodule
